pipes_scroller: RTL and testbench

Per-frame controller that sits directly upstream of the pipe list. On each frame tick it walks the list once through the list's iterate port, shifts every pipe left by the current scroll speed, removes pipes that leave the screen, pulses a score event when a pipe passes the bird, and periodically inserts a new pipe with a pseudo-random gap height. It owns the list's `insert_*` and `iter_*` control inputs and shares its `ce`.

---
 rtl/pipes_scroller.sv | 169 ++++++++++++++++
 tb/tb_pipes_scroller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipes_scroller.sv
// Per-frame pipe list controller: walks the list once per frame tick, scrolls and culls
// pipes, pulses score events at the bird line and periodically spawns a new pipe.
module pipes_scroller #(
   parameter int unsigned X_WIDTH      = 11,
   parameter int unsigned Y_WIDTH      = 10,
   parameter int unsigned SPAWN_X      = 640,
   parameter int unsigned BIRD_X       = 100,
   parameter int unsigned SPAWN_PERIOD = 90,
   parameter int unsigned GAP_MIN      = 80,
   parameter int unsigned MAX_PIPES    = 16,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ce,
   input  logic                       frame_start,
   input  logic [3:0]                 speed,
   output logic                       insert_en,
   output logic [X_WIDTH+Y_WIDTH-1:0] insert_data,
   output logic                       iter_start,
   input  logic                       iter_done,
   input  logic [X_WIDTH+Y_WIDTH-1:0] iter_out,
   output logic [X_WIDTH+Y_WIDTH-1:0] iter_in,
   output logic                       iter_remove,
   output logic                       score_inc,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned CNT_W = $clog2(MAX_PIPES + 1);
   localparam int unsigned SPC_W = $clog2(SPAWN_PERIOD + 1);

   localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_PIPES);
   localparam logic [SPC_W-1:0]   SPAWN_LAST = SPC_W'(SPAWN_PERIOD - 1);
   localparam logic [X_WIDTH-1:0] SPAWN_XV   = X_WIDTH'(SPAWN_X);
   localparam logic [X_WIDTH-1:0] BIRD_XV    = X_WIDTH'(BIRD_X);
   localparam logic [Y_WIDTH-1:0] GAP_MINV   = Y_WIDTH'(GAP_MIN);

   // Field order matches the list's packed element: x in the upper bits.
   typedef struct packed {
      logic [X_WIDTH-1:0] x;
      logic [Y_WIDTH-1:0] gap_y;
   } pipe_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_SPAWN = 2'd2
   } state_e;

   state_e           state_q,     state_d;
   logic [SPC_W-1:0] spawn_cnt_q, spawn_cnt_d;
   logic             spawn_due_q, spawn_due_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [15:0]      lfsr_q,      lfsr_d;
   logic             overrun_q,   overrun_d;

   pipe_t              cur;
   pipe_t              spawn_pipe;
   logic [X_WIDTH-1:0] speed_x;
   logic [X_WIDTH-1:0] new_x;
   logic               off_screen;
   logic               crosses;
   logic               has_room;
   logic               lfsr_fb;

   // Element datapath: the subtraction result is only used when it cannot wrap.
   assign cur        = iter_out;
   assign speed_x    = X_WIDTH'(speed);
   assign off_screen = cur.x < speed_x;
   assign new_x      = cur.x - speed_x;
   assign crosses    = (cur.x >= BIRD_XV) && (off_screen || (new_x < BIRD_XV));
   assign has_room   = count_q < MAX_CNT;
   assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   assign spawn_pipe.x     = SPAWN_XV;
   assign spawn_pipe.gap_y = GAP_MINV + Y_WIDTH'(lfsr_q[7:0]);

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         spawn_cnt_q <= '0;
         spawn_due_q <= 1'b0;
         count_q     <= '0;
         lfsr_q      <= LFSR_SEED;
         overrun_q   <= 1'b0;
      end else if (ce) begin
         state_q     <= state_d;
         spawn_cnt_q <= spawn_cnt_d;
         spawn_due_q <= spawn_due_d;
         count_q     <= count_d;
         lfsr_q      <= lfsr_d;
         overrun_q   <= overrun_d;
      end
   end

   // NOTE: every variable gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      spawn_cnt_d = spawn_cnt_q;
      spawn_due_d = spawn_due_q;
      count_d     = count_q;
      lfsr_d      = lfsr_q;
      overrun_d   = overrun_q;
      unique case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_ITER;
               lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
               if (spawn_cnt_q == SPAWN_LAST) begin
                  spawn_cnt_d = '0;
                  spawn_due_d = 1'b1;
               end else begin
                  spawn_cnt_d = spawn_cnt_q + SPC_W'(1);
               end
            end
         end
         S_ITER: begin
            if (frame_start) overrun_d = 1'b1;
            if (iter_done) begin
               state_d = spawn_due_q ? S_SPAWN : S_IDLE;
            end else if (off_screen) begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_SPAWN: begin
            if (frame_start) overrun_d = 1'b1;
            if (has_room) count_d = count_q + CNT_W'(1);
            spawn_due_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are held low while reset is asserted so the list sees no stray commands.
   always_comb begin
      iter_start  = 1'b0;
      iter_remove = 1'b0;
      iter_in     = '0;
      score_inc   = 1'b0;
      insert_en   = 1'b0;
      insert_data = '0;
      if (rst_n) begin
         unique case (state_q)
            S_IDLE: iter_start = frame_start;
            S_ITER: begin
               if (!iter_done) begin
                  iter_remove = off_screen;
                  score_inc   = crosses;
                  if (!off_screen) iter_in = {new_x, cur.gap_y};
               end
            end
            S_SPAWN: begin
               if (has_room) begin
                  insert_en   = 1'b1;
                  insert_data = spawn_pipe;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pipes_scroller.sv
// Bench for pipes_scroller: emulates the pipe list and checks each frame against a
// frame-level model of scrolling, culling, scoring and spawning.
module tb_pipes_scroller;

   localparam int XW = 11;
   localparam int YW = 10;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] gap_y;
   } pipe_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       frame_start = 1'b0;
   logic [3:0] speed = 4'd0;
   logic       insert_en, iter_start, iter_remove, score_inc, busy, overrun;
   logic       iter_done = 1'b1;
   pipe_t      iter_out = '0;
   pipe_t      iter_in, insert_data;

   pipes_scroller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .frame_start (frame_start),
      .speed       (speed),
      .insert_en   (insert_en),
      .insert_data (insert_data),
      .iter_start  (iter_start),
      .iter_done   (iter_done),
      .iter_out    (iter_out),
      .iter_in     (iter_in),
      .iter_remove (iter_remove),
      .score_inc   (score_inc),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // ---------------- list emulator (the block downstream of the DUT) ----------------
   pipe_t lst[$];
   int    pos = 0;
   bit    active = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         lst.delete();
         active = 1'b0;
         pos    = 0;
         iter_done <= 1'b1;
         iter_out  <= '0;
      end else if (ce) begin
         if (insert_en) lst.push_back(insert_data);
         if (active && pos < lst.size()) begin
            if (iter_remove) lst.delete(pos);
            else begin
               lst[pos] = iter_in;
               pos++;
            end
         end
         if (iter_start) begin
            active = 1'b1;
            pos    = 0;
         end
         if (pos >= lst.size()) active = 1'b0;
         iter_done <= !active;
         iter_out  <= active ? lst[pos] : '0;
      end
   end

   // ---------------- frame-level reference model ----------------
   pipe_t       mq[$];
   int          m_frames;
   logic [15:0] m_lfsr;
   bit          m_ovr;

   int    g_ins_total, g_score_total, g_last_ins_frame, g_last_scores;
   pipe_t g_last_ins;
   bit    g_full_seen;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] b;
      b = (v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5);
      return (v >> 1) | ((b & 16'd1) << 15);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_frames = 0;
      m_lfsr   = 16'hACE1;
      m_ovr    = 1'b0;
   endtask

   // Runs one accepted frame starting at a negedge; optionally injects a second
   // frame_start during the pass and/or randomly stalls ce.
   task automatic do_frame(input int spd, input bit inject, input bit rnd_ce);
      pipe_t nq[$];
      pipe_t p;
      int    n_old, exp_busy, exp_scores, exp_ins;
      int    busy_c, scores, ins, cyc, ox, nx;
      bit    due;

      n_old    = mq.size();
      m_frames++;
      m_lfsr   = lfsr_step(m_lfsr);
      due      = (m_frames % 90) == 0;
      exp_scores = 0;
      foreach (mq[i]) begin
         ox = int'(mq[i].x);
         nx = ox - spd;
         if (ox >= 100 && nx < 100) exp_scores++;
         if (ox >= spd) begin
            p.x     = XW'(nx);
            p.gap_y = mq[i].gap_y;
            nq.push_back(p);
         end
      end
      exp_ins = 0;
      if (due && nq.size() >= 16) g_full_seen = 1'b1;
      if (due && nq.size() < 16) begin
         exp_ins = 1;
         p.x     = XW'(640);
         p.gap_y = YW'(80 + int'(m_lfsr[7:0]));
         nq.push_back(p);
      end
      exp_busy = n_old + 1 + (due ? 1 : 0);
      mq = nq;
      if (inject) m_ovr = 1'b1;

      ce = 1'b1;
      speed = 4'(spd);
      frame_start = 1'b1;
      #1;
      check("iter_start", iter_start, 1);
      check("idle_busy", busy, 0);
      @(negedge clk);
      busy_c = 0; scores = 0; ins = 0; cyc = 0;
      while (busy && cyc < 100) begin
         frame_start = inject && cyc == 0;
         if (rnd_ce && !(inject && cyc == 0)) ce = ($urandom_range(0, 3) != 0);
         else ce = 1'b1;
         if (ce) begin
            busy_c++;
            if (score_inc) scores++;
            if (insert_en) begin
               ins++;
               g_last_ins = insert_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      frame_start = 1'b0;
      ce = 1'b1;

      check("pass_end", busy, 0);
      check("busy_cycles", busy_c, exp_busy);
      check("score_pulses", scores, exp_scores);
      check("inserts", ins, exp_ins);
      check("overrun", overrun, m_ovr);
      check("list_len", lst.size(), mq.size());
      for (int i = 0; i < mq.size() && i < lst.size(); i++) begin
         check("elem_x", lst[i].x, mq[i].x);
         check("elem_gap", lst[i].gap_y, mq[i].gap_y);
      end
      g_ins_total   += ins;
      g_score_total += scores;
      g_last_scores  = scores;
      if (ins > 0) g_last_ins_frame = m_frames;
   endtask

   initial begin
      logic [15:0] l90;
      int guard;

      // Reset with ce low: reset must still take effect.
      model_reset();
      rst_n = 1'b0;
      ce    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_insert_en", insert_en, 0);
      check("rst_iter_start", iter_start, 0);
      check("rst_iter_remove", iter_remove, 0);
      check("rst_score_inc", score_inc, 0);
      rst_n = 1'b1;
      ce    = 1'b1;
      @(negedge clk);

      // Empty list, 90 widely spaced frames: a single spawn on frame 90.
      g_ins_total = 0; g_score_total = 0; g_last_ins_frame = 0;
      for (int f = 0; f < 90; f++) begin
         do_frame($urandom_range(0, 15), 1'b0, 1'b0);
         repeat (195) @(negedge clk);
      end
      l90 = 16'hACE1;
      for (int i = 0; i < 90; i++) l90 = lfsr_step(l90);
      check("p1_inserts", g_ins_total, 1);
      check("p1_insert_frame", g_last_ins_frame, 90);
      check("p1_insert_x", g_last_ins.x, 640);
      check("p1_insert_gap", g_last_ins.gap_y, 80 + int'(l90[7:0]));
      check("p1_scores", g_score_total, 0);

      // Random speeds with ce stalls; one dropped frame_start midway.
      for (int f = 0; f < 300; f++) begin
         do_frame($urandom_range(0, 15), f == 150, 1'b1);
         if (f == 150) check("overrun_set", overrun, 1);
      end

      // Fill the list at speed 0 until a spawn finds it full.
      g_full_seen = 1'b0;
      guard = 0;
      while (!g_full_seen && guard < 2500) begin
         do_frame(0, 1'b0, 1'b0);
         guard++;
      end
      check("full_spawn_seen", g_full_seen, 1);
      check("full_len", lst.size(), 16);

      // Reset in the middle of a pass over a full list.
      ce = 1'b1;
      speed = 4'd0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      check("mid_iter_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_insert_en", insert_en, 0);
      check("rst_mid_iter_remove", iter_remove, 0);
      check("rst_mid_score_inc", score_inc, 0);
      check("rst_mid_iter_start", iter_start, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_overrun", overrun, 0);
      model_reset();
      do_frame(0, 1'b0, 1'b0);
      check("post_rst_empty", lst.size(), 0);

      // Bring one pipe to x=104, then cross the bird line with speed 3.
      for (int f = 1; f < 90; f++) do_frame(0, 1'b0, 1'b0);
      for (int f = 0; f < 35; f++) do_frame(15, 1'b0, 1'b0);
      do_frame(11, 1'b0, 1'b0);
      check("dir_x104", lst[0].x, 104);
      do_frame(3, 1'b0, 1'b0);
      check("dir_x101", lst[0].x, 101);
      check("dir_score0", g_last_scores, 0);
      do_frame(3, 1'b0, 1'b0);
      check("dir_x98", lst[0].x, 98);
      check("dir_score1", g_last_scores, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
